// File: rtl/taller_ram_pkg.sv
// Shared definitions for the two-channel arbitrated RAM: control states and channel ids.
package taller_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

endpackage

// File: rtl/taller_ram_core.sv
// Single-port byte-enabled RAM with registered read; one narrow array per byte lane
// so each lane maps cleanly onto block RAM with its own write enable.
module taller_ram_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rdata;

            // Read data holds while disabled, which keeps returns stable across stalls.
            always_ff @(posedge clk) begin
                if (i_en) begin
                    if (i_we && i_be[gi]) begin
                        r_mem[i_addr] <= i_wdata[gi*8 +: 8];
                    end
                    r_rdata <= r_mem[i_addr];
                end
            end

            assign o_rdata[gi*8 +: 8] = r_rdata;
        end
    endgenerate

endmodule

// File: rtl/taller_ram_arb.sv
// Two Avalon-MM pipelined slave channels sharing one single-port RAM: round-robin
// arbitration, post-reset zero fill and a stall-aware, channel-tagged read return pipe.
module taller_ram_arb
    import taller_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 12,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  freeze,
    output logic                  init_done,

    input  logic [ADDR_W-1:0]     a_address,
    input  logic [DATA_W/8-1:0]   a_byteenable,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [DATA_W-1:0]     a_writedata,
    output logic                  a_waitrequest,
    output logic [DATA_W-1:0]     a_readdata,
    output logic                  a_readdatavalid,

    input  logic [ADDR_W-1:0]     b_address,
    input  logic [DATA_W/8-1:0]   b_byteenable,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [DATA_W-1:0]     b_writedata,
    output logic                  b_waitrequest,
    output logic [DATA_W-1:0]     b_readdata,
    output logic                  b_readdatavalid
);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                r_init_done;
    logic                r_rr;
    logic                r_v1;
    logic                r_ch1;

    logic                w_en;
    logic                w_ready;
    logic                w_req_a;
    logic                w_req_b;
    logic                w_gnt_a;
    logic                w_gnt_b;
    logic                w_rd_acc;
    logic                w_rd_ch;

    logic                w_mem_en;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W/8-1:0] w_mem_be;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [DATA_W-1:0]   w_core_rdata;

    logic                w_ret_v;
    logic                w_ret_ch;
    logic [DATA_W-1:0]   w_ret_data;
    logic                w_ret_a;
    logic                w_ret_b;

    assign w_en    = clken & ~freeze;
    // r_init_done resets asynchronously, so waitrequest rises the moment reset_n drops.
    assign w_ready = r_init_done & w_en;
    assign w_req_a = a_read | a_write;
    assign w_req_b = b_read | b_write;
    assign w_gnt_a = w_ready & w_req_a & (~w_req_b | (r_rr == CH_A));
    assign w_gnt_b = w_ready & w_req_b & (~w_req_a | (r_rr == CH_B));

    assign a_waitrequest = ~w_ready | (w_req_a & ~w_gnt_a);
    assign b_waitrequest = ~w_ready | (w_req_b & ~w_gnt_b);
    assign init_done     = r_init_done;

    assign w_rd_acc = (w_gnt_a & ~a_write) | (w_gnt_b & ~b_write);
    assign w_rd_ch  = w_gnt_b ? CH_B : CH_A;

    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = a_address;
        w_mem_be    = a_byteenable;
        w_mem_wdata = a_writedata;
        if (r_state == ST_CLEAR) begin
            w_mem_en    = w_en;
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_addr;
            w_mem_be    = '1;
            w_mem_wdata = '0;
        end else if (w_gnt_b) begin
            w_mem_en    = 1'b1;
            w_mem_we    = b_write;
            w_mem_addr  = b_address;
            w_mem_be    = b_byteenable;
            w_mem_wdata = b_writedata;
        end else if (w_gnt_a) begin
            w_mem_en    = 1'b1;
            w_mem_we    = a_write;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_clr_addr  <= '0;
            r_init_done <= 1'b0;
            r_rr        <= CH_A;
            r_v1        <= 1'b0;
            r_ch1       <= CH_A;
        end else begin
            if (r_state == ST_CLEAR) begin
                if (w_en) begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (&r_clr_addr) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
            end else begin
                r_init_done <= 1'b1;
            end
            if (w_ready && w_req_a && w_req_b) begin
                r_rr <= ~r_rr;
            end
            if (w_en) begin
                r_v1  <= w_rd_acc;
                r_ch1 <= w_rd_ch;
            end
        end
    end

    taller_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_be    (w_mem_be),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_core_rdata)
    );

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              r_v2;
            logic              r_ch2;
            logic [DATA_W-1:0] r_data2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_v2    <= 1'b0;
                    r_ch2   <= CH_A;
                    r_data2 <= '0;
                end else if (w_en) begin
                    r_v2    <= r_v1;
                    r_ch2   <= r_ch1;
                    r_data2 <= w_core_rdata;
                end
            end

            assign w_ret_v    = r_v2;
            assign w_ret_ch   = r_ch2;
            assign w_ret_data = r_data2;
        end else begin : g_noreg
            assign w_ret_v    = r_v1;
            assign w_ret_ch   = r_ch1;
            assign w_ret_data = w_core_rdata;
        end
    endgenerate

    // A return is only presented in an enabled cycle; during a stall it waits in place.
    assign w_ret_a = w_ret_v & w_en & (w_ret_ch == CH_A);
    assign w_ret_b = w_ret_v & w_en & (w_ret_ch == CH_B);

    assign a_readdatavalid = w_ret_a;
    assign b_readdatavalid = w_ret_b;
    assign a_readdata      = w_ret_a ? w_ret_data : '0;
    assign b_readdata      = w_ret_b ? w_ret_data : '0;

endmodule
